// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence feeder and its point store.
package geofence_pkg;

    localparam int NPTS  = 6;
    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int R_W   = 11;
    localparam int IDX_W = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [R_W-1:0] r;
    } point_t;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STREAM,
        ST_WAIT
    } feed_state_t;

endpackage

// File: rtl/geofence_point_buf.sv
// Two-slot ping-pong store of 6-point objects with per-slot tag and full flag.
module geofence_point_buf
    import geofence_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  point_t           wr_point,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_release,
    output logic             rd_full,
    output point_t           rd_point,
    output logic [TAG_W-1:0] rd_tag
);

    point_t           mem_q [2][NPTS];
    point_t           mem_d [2][NPTS];
    logic [TAG_W-1:0] tag_q [2];
    logic [TAG_W-1:0] tag_d [2];
    logic [1:0]       full_q, full_d;
    logic             wr_slot_q, wr_slot_d;
    logic             rd_slot_q, rd_slot_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_fire;

    assign wr_ready = !full_q[wr_slot_q];
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_full  = full_q[rd_slot_q];
    assign rd_tag   = tag_q[rd_slot_q];
    assign rd_point = (rd_idx < IDX_W'(NPTS)) ? mem_q[rd_slot_q][rd_idx] : '0;

    // Release frees the slot being read; a completed write marks its slot full and flips slots.
    always_comb begin
        mem_d     = mem_q;
        tag_d     = tag_q;
        full_d    = full_q;
        wr_slot_d = wr_slot_q;
        wr_idx_d  = wr_idx_q;
        rd_slot_d = rd_slot_q;
        if (rd_release) begin
            full_d[rd_slot_q] = 1'b0;
            rd_slot_d         = !rd_slot_q;
        end
        if (wr_fire) begin
            mem_d[wr_slot_q][wr_idx_q] = wr_point;
            if (wr_idx_q == '0) begin
                tag_d[wr_slot_q] = wr_tag;
            end
            if (wr_idx_q == IDX_W'(NPTS - 1)) begin
                full_d[wr_slot_q] = 1'b1;
                wr_slot_d         = !wr_slot_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // Point storage needs no reset: only slots flagged full are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state and tags clear asynchronously so a reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '{default: '0};
            full_q    <= '0;
            wr_slot_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_slot_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            full_q    <= full_d;
            wr_slot_q <= wr_slot_d;
            wr_idx_q  <= wr_idx_d;
            rd_slot_q <= rd_slot_d;
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// Feeds buffered 6-point objects into geofence on its fixed capture schedule and tags its verdicts.
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int NPTS  = 6,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_x,
    input  logic [Y_W-1:0]   in_y,
    input  logic [R_W-1:0]   in_r,
    input  logic [TAG_W-1:0] in_tag,
    output logic             gf_reset,
    output logic [X_W-1:0]   gf_x,
    output logic [Y_W-1:0]   gf_y,
    output logic [R_W-1:0]   gf_r,
    input  logic             gf_valid,
    input  logic             gf_is_inside,
    output logic             res_valid,
    output logic             res_inside,
    output logic [TAG_W-1:0] res_tag
);

    feed_state_t      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             gf_reset_q, gf_reset_d;
    point_t           bus_q, bus_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
    logic             res_valid_q, res_valid_d;
    logic             res_inside_q, res_inside_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;

    point_t           in_point;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_release;
    logic             rd_full;
    point_t           rd_point;
    logic [TAG_W-1:0] rd_tag;
    logic             last_point;

    assign in_point   = {in_x, in_y, in_r};
    assign last_point = (cnt_q == IDX_W'(NPTS - 1));

    // While streaming, fetch the point that goes on the bus next; otherwise point 0 is staged.
    assign rd_idx     = (state_q == ST_STREAM && !last_point) ? cnt_q + 1'b1 : '0;
    assign rd_release = (state_q == ST_STREAM) && last_point;

    geofence_point_buf #(
        .TAG_W (TAG_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_valid   (in_valid),
        .wr_ready   (in_ready),
        .wr_point   (in_point),
        .wr_tag     (in_tag),
        .rd_idx     (rd_idx),
        .rd_release (rd_release),
        .rd_full    (rd_full),
        .rd_point   (rd_point),
        .rd_tag     (rd_tag)
    );

    // Next-state logic: hold geofence in reset until an object is ready, stream it, then await the verdict.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gf_reset_d   = gf_reset_q;
        bus_d        = bus_q;
        cur_tag_d    = cur_tag_q;
        res_valid_d  = 1'b0;
        res_inside_d = res_inside_q;
        res_tag_d    = res_tag_q;
        case (state_q)
            ST_HOLD: begin
                gf_reset_d = 1'b1;
                bus_d      = '0;
                if (rd_full) begin
                    gf_reset_d = 1'b0;
                    bus_d      = rd_point;
                    cur_tag_d  = rd_tag;
                    cnt_d      = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_point) begin
                    bus_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    bus_d = rd_point;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                bus_d = '0;
                if (gf_valid) begin
                    res_valid_d  = 1'b1;
                    res_inside_d = gf_is_inside;
                    res_tag_d    = cur_tag_q;
                    if (rd_full) begin
                        bus_d     = rd_point;
                        cur_tag_d = rd_tag;
                        cnt_d     = '0;
                        state_d   = ST_STREAM;
                    end else begin
                        gf_reset_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            default: begin
                gf_reset_d = 1'b1;
                bus_d      = '0;
                state_d    = ST_HOLD;
            end
        endcase
    end

    // State, bus and result registers; reset drops any pending result and reasserts gf_reset at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            gf_reset_q   <= 1'b1;
            bus_q        <= '0;
            cur_tag_q    <= '0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gf_reset_q   <= gf_reset_d;
            bus_q        <= bus_d;
            cur_tag_q    <= cur_tag_d;
            res_valid_q  <= res_valid_d;
            res_inside_q <= res_inside_d;
            res_tag_q    <= res_tag_d;
        end
    end

    assign gf_reset   = gf_reset_q;
    assign gf_x       = bus_q.x;
    assign gf_y       = bus_q.y;
    assign gf_r       = bus_q.r;
    assign res_valid  = res_valid_q;
    assign res_inside = res_inside_q;
    assign res_tag    = res_tag_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// Self-checking bench for geofence_feeder: directed scenarios plus a randomized run
// compared every cycle against an object-queue reference model.
`timescale 1ns/1ps
module tb_geofence_feeder;

    typedef struct packed {
        logic [7:0]       tag;
        logic [5:0][30:0] pts;
    } obj_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [10:0] in_r;
    logic [7:0]  in_tag;
    logic        gf_reset;
    logic [9:0]  gf_x;
    logic [9:0]  gf_y;
    logic [10:0] gf_r;
    logic        gf_valid;
    logic        gf_is_inside;
    logic        res_valid;
    logic        res_inside;
    logic [7:0]  res_tag;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: complete objects held in the store, the one being assembled,
    // and where the geofence side currently is.
    obj_t       stored[$];
    obj_t       partial;
    int         part_cnt;
    int         m_pos;
    logic       m_gf_reset;
    logic       m_res_valid;
    logic       m_res_inside;
    logic [7:0] m_res_tag;
    logic [7:0] m_judged_tag;

    logic [63:0] obs_vec;
    logic        obs_gf_reset;
    logic        obs_in_ready;
    logic        obs_res_valid;
    logic        obs_res_inside;
    logic [7:0]  obs_res_tag;
    logic [30:0] obs_bus;

    geofence_feeder #(
        .NPTS  (6),
        .TAG_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_r         (in_r),
        .in_tag       (in_tag),
        .gf_reset     (gf_reset),
        .gf_x         (gf_x),
        .gf_y         (gf_y),
        .gf_r         (gf_r),
        .gf_valid     (gf_valid),
        .gf_is_inside (gf_is_inside),
        .res_valid    (res_valid),
        .res_inside   (res_inside),
        .res_tag      (res_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] pt(input int x, input int y, input int r);
        return {x[9:0], y[9:0], r[10:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic modelReset();
        stored.delete();
        partial      = '0;
        part_cnt     = 0;
        m_pos        = -1;
        m_gf_reset   = 1'b1;
        m_res_valid  = 1'b0;
        m_res_inside = 1'b0;
        m_res_tag    = '0;
        m_judged_tag = '0;
    endtask

    // Expected outputs for the current cycle, packed the same way as the observed vector.
    function automatic logic [63:0] modelVec();
        logic [30:0] b;
        b = '0;
        if (m_pos >= 0) b = stored[0].pts[m_pos];
        return {21'd0, m_gf_reset, b, m_res_valid, m_res_inside, m_res_tag, (stored.size() < 2)};
    endfunction

    // Advance the model by one clock using the inputs presented during the cycle.
    task automatic modelStep(input logic v, input logic [9:0] x, input logic [9:0] y,
                             input logic [10:0] r, input logic [7:0] tag,
                             input logic gv, input logic gi);
        int   held;
        logic acc;
        held        = stored.size();
        acc         = v && (held < 2);
        m_res_valid = 1'b0;
        if (m_pos >= 0) begin
            if (m_pos == 5) begin
                m_judged_tag = stored[0].tag;
                void'(stored.pop_front());
                m_pos = -1;
            end else begin
                m_pos++;
            end
        end else if (m_gf_reset) begin
            if (held > 0) begin
                m_gf_reset = 1'b0;
                m_pos      = 0;
            end
        end else if (gv) begin
            m_res_valid  = 1'b1;
            m_res_inside = gi;
            m_res_tag    = m_judged_tag;
            if (held > 0) m_pos = 0;
            else          m_gf_reset = 1'b1;
        end
        if (acc) begin
            if (part_cnt == 0) partial.tag = tag;
            partial.pts[part_cnt] = {x, y, r};
            part_cnt++;
            if (part_cnt == 6) begin
                stored.push_back(partial);
                part_cnt = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [9:0] x, input logic [9:0] y,
                                 input logic [10:0] r, input logic [7:0] tag,
                                 input logic gv, input logic gi);
        in_valid     = v;
        in_x         = x;
        in_y         = y;
        in_r         = r;
        in_tag       = tag;
        gf_valid     = gv;
        gf_is_inside = gi;
        @(negedge clk);
        obs_gf_reset   = gf_reset;
        obs_in_ready   = in_ready;
        obs_res_valid  = res_valid;
        obs_res_inside = res_inside;
        obs_res_tag    = res_tag;
        obs_bus        = {gf_x, gf_y, gf_r};
        obs_vec        = {21'd0, gf_reset, gf_x, gf_y, gf_r, res_valid, res_inside, res_tag, in_ready};
        checkOutput("cycle", obs_vec, modelVec());
        modelStep(v, x, y, r, tag, gv, gi);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic gv, input logic gi);
        applyStimulus(1'b0, '0, '0, '0, '0, gv, gi);
    endtask

    task automatic sendRec(input int x, input int y, input int r, input logic [7:0] tag);
        applyStimulus(1'b1, 10'(x), 10'(y), 11'(r), tag, 1'b0, 1'b0);
    endtask

    initial begin
        int hs;
        int since12;
        int guard;
        int o;
        int p;
        int res_seen;
        in_valid     = 1'b0;
        in_x         = '0;
        in_y         = '0;
        in_r         = '0;
        in_tag       = '0;
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        modelReset();

        #2 reset = 1'b0;
        #10;
        checkOutput("rst_gf_reset", 64'(gf_reset), 64'd1);
        checkOutput("rst_bus", 64'({gf_x, gf_y, gf_r}), 64'd0);
        checkOutput("rst_res", 64'({res_valid, res_inside, res_tag}), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        #11 reset = 1'b1;
        @(posedge clk);
        #1;

        // One object, no gaps, then an inside verdict.
        for (int k = 1; k <= 6; k++) sendRec(k, k, 5, 8'h11);
        idle(1'b0, 1'b0);
        checkOutput("t1_gfreset_c1", 64'(obs_gf_reset), 64'd1);
        idle(1'b0, 1'b0);
        checkOutput("t1_gfreset_c2", 64'(obs_gf_reset), 64'd0);
        checkOutput("t1_pt1", 64'(obs_bus), 64'(pt(1, 1, 5)));
        for (int k = 2; k <= 6; k++) begin
            idle(1'b0, 1'b0);
            checkOutput("t1_pt", 64'(obs_bus), 64'(pt(k, k, 5)));
        end
        idle(1'b1, 1'b1);
        checkOutput("t1_wait", 64'({obs_gf_reset, obs_bus}), 64'd0);
        idle(1'b0, 1'b0);
        checkOutput("t1_res", 64'({obs_res_valid, obs_res_inside, obs_res_tag}), 64'({1'b1, 1'b1, 8'h11}));
        checkOutput("t1_hold", 64'(obs_gf_reset), 64'd1);
        idle(1'b0, 1'b0);
        checkOutput("t1_res_pulse", 64'(obs_res_valid), 64'd0);

        // Three objects back to back with no verdicts: back-pressure after the 12th record.
        hs      = 0;
        since12 = 0;
        guard   = 0;
        while (hs < 18 && guard < 100) begin
            o = hs / 6 + 1;
            p = hs % 6;
            applyStimulus(1'b1, 10'(o * 16 + p), 10'(o * 32 + p), 11'(o * 64 + p),
                          (p == 0) ? 8'(o) : 8'hEE, 1'b0, 1'b0);
            if (since12 == 1) begin
                checkOutput("t2_ready_drop", 64'(obs_in_ready), 64'd0);
                checkOutput("t2_obj1_pt5", 64'(obs_bus), 64'(pt(21, 37, 69)));
            end
            if (since12 == 2) checkOutput("t2_ready_rise", 64'(obs_in_ready), 64'd1);
            if (since12 > 0) since12++;
            if (obs_in_ready) begin
                hs++;
                if (hs == 12) since12 = 1;
            end
            guard++;
        end
        if (guard >= 100) checkOutput("t2_timeout", 64'(hs), 64'd18);
        idle(1'b0, 1'b0);
        checkOutput("t2_both_full", 64'({obs_in_ready, obs_gf_reset}), 64'd0);

        // Next object already full when the verdict arrives: no reset gap.
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("t3_no_reset", 64'(obs_gf_reset), 64'd0);
        checkOutput("t3_obj2_pt0", 64'(obs_bus), 64'(pt(32, 64, 128)));
        checkOutput("t3_res1", 64'({obs_res_valid, obs_res_inside, obs_res_tag}), 64'({1'b1, 1'b0, 8'h01}));
        for (int k = 1; k <= 5; k++) begin
            idle(1'b0, 1'b0);
            checkOutput("t3_obj2_pt", 64'(obs_bus), 64'(pt(32 + k, 64 + k, 128 + k)));
        end
        idle(1'b1, 1'b1);
        checkOutput("t3_wait", 64'({obs_gf_reset, obs_bus}), 64'd0);
        idle(1'b0, 1'b0);
        checkOutput("t3_obj3_pt0", 64'(obs_bus), 64'(pt(48, 96, 192)));
        checkOutput("t3_res2", 64'({obs_res_valid, obs_res_inside, obs_res_tag}), 64'({1'b1, 1'b1, 8'h02}));
        for (int k = 1; k <= 5; k++) idle(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("t3_res3", 64'({obs_res_valid, obs_res_inside, obs_res_tag}), 64'({1'b1, 1'b1, 8'h03}));
        checkOutput("t3_hold", 64'({obs_gf_reset, obs_in_ready}), 64'b11);

        // Next object only 4 of 6 points when the verdict arrives.
        for (int k = 0; k < 6; k++) sendRec(100 + k, 200 + k, 300 + k, 8'h21);
        for (int k = 0; k < 4; k++) sendRec(400 + k, 500 + k, 600 + k, 8'h22);
        for (int k = 0; k < 3; k++) idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        checkOutput("t4_wait", 64'({obs_gf_reset, obs_bus}), 64'd0);
        idle(1'b0, 1'b0);
        checkOutput("t4_reassert", 64'(obs_gf_reset), 64'd1);
        checkOutput("t4_res", 64'({obs_res_valid, obs_res_inside, obs_res_tag}), 64'({1'b1, 1'b0, 8'h21}));
        idle(1'b0, 1'b0);
        checkOutput("t4_held", 64'(obs_gf_reset), 64'd1);
        sendRec(404, 504, 604, 8'h22);
        sendRec(405, 505, 605, 8'h22);
        checkOutput("t4_held_6th", 64'(obs_gf_reset), 64'd1);
        idle(1'b0, 1'b0);
        checkOutput("t4_held_c1", 64'(obs_gf_reset), 64'd1);
        idle(1'b0, 1'b0);
        checkOutput("t4_release", 64'(obs_gf_reset), 64'd0);
        checkOutput("t4_pt0", 64'(obs_bus), 64'(pt(400, 500, 600)));
        for (int k = 1; k <= 5; k++) begin
            idle(1'b0, 1'b0);
            checkOutput("t4_pt", 64'(obs_bus), 64'(pt(400 + k, 500 + k, 600 + k)));
        end
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("t4_res2", 64'({obs_res_valid, obs_res_inside, obs_res_tag}), 64'({1'b1, 1'b1, 8'h22}));

        // Reset in the middle of a stream, with a partial object also buffered.
        for (int k = 0; k < 6; k++) sendRec(700 + k, 800 + k, 900 + k, 8'h31);
        for (int k = 0; k < 3; k++) sendRec(50 + k, 60 + k, 70 + k, 8'h32);
        idle(1'b0, 1'b0);
        checkOutput("t5_pt3", 64'({gf_reset, gf_x, gf_y, gf_r}), 64'({1'b0, pt(703, 803, 903)}));
        reset = 1'b0;
        #1;
        checkOutput("t5_async_gfreset", 64'(gf_reset), 64'd1);
        checkOutput("t5_async_bus", 64'({gf_x, gf_y, gf_r}), 64'd0);
        checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
        modelReset();
        #1 reset = 1'b1;
        res_seen = 0;
        for (int k = 0; k < 10; k++) begin
            idle(k[0], 1'b1);
            res_seen += int'(obs_res_valid);
        end
        checkOutput("t5_no_res", 64'(res_seen), 64'd0);
        for (int k = 0; k < 6; k++) sendRec(1 + k, 2 + k, 3 + k, 8'h41);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("t5_fresh_pt0", 64'({obs_gf_reset, obs_bus}), 64'({1'b0, pt(1, 2, 3)}));
        for (int k = 1; k <= 5; k++) idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("t5_res", 64'({obs_res_valid, obs_res_tag}), 64'({1'b1, 8'h41}));

        // Randomized traffic with random verdict timing, checked cycle by cycle.
        res_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 10'($urandom), 10'($urandom), 11'($urandom),
                          8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
            res_seen += int'(obs_res_valid);
        end
        checkOutput("rand_progress", 64'(res_seen > 20), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
